// File: rtl/cs_pkg.sv
// Shared CSR definitions for the machine-mode CSR file: addresses, access ops,
// mstatus/mie/mip bit positions and fixed identification values.
package cs_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // CSR access operations as sent by the decoder
  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Register bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIP_MEIP_BIT     = 11;

  localparam logic [31:0] MISA_RV32I  = 32'h4000_0100;
  localparam logic [1:0]  PRIV_M      = 2'b11;
  // Clears bits 1:0 of mepc/mtvec (word aligned, direct mode)
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  // Read-modify-write result of a CSR instruction
  function automatic logic [31:0] csr_modify(input logic [1:0] op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_OP_WRITE: res = operand;
      CSR_OP_SET:   res = old_val | operand;
      CSR_OP_CLEAR: res = old_val & ~operand;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cs_registers_m_counter64.sv
// Up to 64-bit event counter exposed as two 32-bit CSR halves. A write to
// either half replaces that half and drops the increment for that cycle.
module cs_counter64 #(
  parameter int C_CNT_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  localparam int HI_W = C_CNT_WIDTH - 32;

  logic [C_CNT_WIDTH-1:0] cnt_q;
  logic [C_CNT_WIDTH-1:0] cnt_d;

  // Next count: CSR half-write wins over the increment; wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[C_CNT_WIDTH-1:32] = wdata_i[HI_W-1:0];
    end else if (inc_i) begin
      cnt_d = cnt_q + C_CNT_WIDTH'(1);
    end
  end

  // Count register, held while the clock enable is low
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt_q <= '0;
    end else if (clk_en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign lo_o = cnt_q[31:0];

  // Upper half zero-extended; unimplemented bits read as 0
  always_comb begin
    hi_o = '0;
    hi_o[HI_W-1:0] = cnt_q[C_CNT_WIDTH-1:32];
  end

endmodule

// File: rtl/cs_registers_m.sv
// Machine-mode CSR file: trap registers, mcycle/minstret counters, CSR
// read-modify-write with illegal-access detection, trap entry and MRET.
module cs_registers_m
  import cs_pkg::*;
#(
  parameter int          C_XLEN        = 32,
  parameter int          C_CNT_WIDTH   = 64,
  parameter logic [31:0] C_HART_ID     = 32'd0,
  parameter logic [31:0] C_MTVEC_RESET = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              clk_en_i,
  input  logic              resetb_i,
  input  logic              access_i,
  input  logic [1:0]        op_i,
  input  logic [11:0]       addr_i,
  input  logic [C_XLEN-1:0] data_i,
  output logic [C_XLEN-1:0] data_o,
  output logic              illegal_access_o,
  output logic [1:0]        hpl_o,
  input  logic              instret_i,
  input  logic              trap_i,
  input  logic [C_XLEN-1:0] trap_cause_i,
  input  logic [C_XLEN-1:0] trap_pc_i,
  input  logic [C_XLEN-1:0] trap_val_i,
  input  logic              mret_i,
  input  logic              irq_ext_i,
  output logic              irq_pending_o,
  output logic [C_XLEN-1:0] trap_vector_o,
  output logic [C_XLEN-1:0] epc_o
);

  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q,     mie_meie_d;
  logic        irq_pending_q,  irq_pending_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;
  logic [31:0] mtval_q,    mtval_d;

  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_hit, csr_wr;

  // Address decode and read mux (value before this cycle's update)
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (addr_i)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]               = mstatus_mie_q;
        csr_rdata[MSTATUS_MPIE_BIT]              = mstatus_mpie_q;
        csr_rdata[MSTATUS_MPP_LSB +: 2]          = PRIV_M;
      end
      CSR_MISA:                        csr_rdata = MISA_RV32I;
      CSR_MIE:                         csr_rdata[MIE_MEIE_BIT] = mie_meie_q;
      CSR_MTVEC:                       csr_rdata = mtvec_q;
      CSR_MSCRATCH:                    csr_rdata = mscratch_q;
      CSR_MEPC:                        csr_rdata = mepc_q;
      CSR_MCAUSE:                      csr_rdata = mcause_q;
      CSR_MTVAL:                       csr_rdata = mtval_q;
      CSR_MIP:                         csr_rdata[MIP_MEIP_BIT] = irq_ext_i;
      CSR_MCYCLE,    CSR_CYCLE:        csr_rdata = mcycle_lo;
      CSR_MCYCLEH,   CSR_CYCLEH:       csr_rdata = mcycle_hi;
      CSR_MINSTRET,  CSR_INSTRET:      csr_rdata = minstret_lo;
      CSR_MINSTRETH, CSR_INSTRETH:     csr_rdata = minstret_hi;
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID:                      csr_rdata = '0;
      CSR_MHARTID:                     csr_rdata = C_HART_ID;
      default:                         csr_hit   = 1'b0;
    endcase
  end

  // Read-only space is addr[11:10]=11; any modifying op there is illegal
  assign illegal_access_o = access_i &
                            (~csr_hit | ((addr_i[11:10] == 2'b11) && (op_i != CSR_OP_READ)));
  assign csr_wr    = access_i & ~illegal_access_o & (op_i != CSR_OP_READ);
  assign csr_wdata = csr_modify(op_i, csr_rdata, data_i);

  // Next state: trap beats MRET beats CSR write
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    irq_pending_d  = mstatus_mie_q & mie_meie_q & irq_ext_i;
    if (trap_i) begin
      mepc_d         = trap_pc_i & ALIGN_MASK;
      mcause_d       = trap_cause_i;
      mtval_d        = trap_val_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_wr) begin
      case (addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
          mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_meie_d = csr_wdata[MIE_MEIE_BIT];
        CSR_MTVEC:    mtvec_d    = csr_wdata & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_d = csr_wdata;
        CSR_MEPC:     mepc_d     = csr_wdata & ALIGN_MASK;
        CSR_MCAUSE:   mcause_d   = csr_wdata;
        CSR_MTVAL:    mtval_d    = csr_wdata;
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset and clock enable
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      irq_pending_q  <= 1'b0;
      mtvec_q        <= C_MTVEC_RESET & ALIGN_MASK;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (clk_en_i) begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      irq_pending_q  <= irq_pending_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  // Counters update regardless of trap/MRET in the same cycle
  cs_counter64 #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_mcycle (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .clk_en_i (clk_en_i),
    .inc_i    (1'b1),
    .wr_lo_i  (csr_wr && (addr_i == CSR_MCYCLE)),
    .wr_hi_i  (csr_wr && (addr_i == CSR_MCYCLEH)),
    .wdata_i  (csr_wdata),
    .lo_o     (mcycle_lo),
    .hi_o     (mcycle_hi)
  );

  cs_counter64 #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_minstret (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .clk_en_i (clk_en_i),
    .inc_i    (instret_i),
    .wr_lo_i  (csr_wr && (addr_i == CSR_MINSTRET)),
    .wr_hi_i  (csr_wr && (addr_i == CSR_MINSTRETH)),
    .wdata_i  (csr_wdata),
    .lo_o     (minstret_lo),
    .hi_o     (minstret_hi)
  );

  assign data_o        = csr_rdata;
  assign hpl_o         = PRIV_M;
  assign irq_pending_o = irq_pending_q;
  assign trap_vector_o = mtvec_q;
  assign epc_o         = mepc_q;

endmodule
